// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encoding and default bit timing.
package uart_defs_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

    // 100 MHz system clock at 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with selectable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ascii_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, frame check, one-byte holding register
// and sticky overrun flag; feeds the letter-case converter's character input.
module ascii_uart_rx
    import uart_defs_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned    CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic          rxs;
    uart_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // A delivery later in this block overrides the handshake clear.
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        cnt   <= HALF_M1;
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rxs) begin
                        cnt   <= FULL_M1;
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg[idx] <= rxs;
                        cnt        <= FULL_M1;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rxs) begin
                        if (!rx_valid || rx_ready) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_uart_rx.sv
// Self-checking bench for ascii_uart_rx at 16 clocks per bit, randomized bytes vs. a queue model.
module tb_ascii_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned cyc    = 0;
    logic [7:0]  got_q[$];
    int unsigned got_t[$];
    int unsigned fe_cnt = 0;
    int unsigned fe_t   = 0;

    ascii_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe accepted bytes and frame errors away from the active edge.
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            got_t.push_back(cyc);
        end
        if (rst_n && frame_err) begin
            fe_cnt++;
            fe_t = cyc;
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int unsigned t0);
        t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(b[i]);
        drive_bit(stop_bit);
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b1;
        idle(3);
        n_checks++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b fe=%b ovr=%b busy=%b, want 00 0 0 0 0",
                     rx_data, rx_valid, frame_err, overrun, busy);
        end
        rst_n = 1'b1;
        idle(5);
        n_checks++;
        if (rx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b busy=%b, want 0 0", rx_valid, busy);
        end
    endtask

    task automatic test_single();
        int unsigned t0;
        int unsigned fe0;
        clear_obs();
        fe0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h61, 1'b1, t0);
        idle(10);
        n_checks++;
        if (got_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d accepted cycles, want 1", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0] !== 8'h61) begin
                n_fail++;
                $display("FAIL single_data: got %h, want 61", got_q[0]);
            end
            n_checks++;
            if (got_t[0] - t0 != LAT) begin
                n_fail++;
                $display("FAIL single_latency: got %0d cycles, want %0d", got_t[0] - t0, LAT);
            end
        end
        n_checks++;
        if (fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL single_frame_err: got %0d pulses, want 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_q[$];
        int unsigned t0;
        exp_q = '{8'h62, 8'h41, 8'h4A};
        clear_obs();
        rx_ready = 1'b1;
        foreach (exp_q[i])
            send_frame(exp_q[i], 1'b1, t0);
        idle(10);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: got %b, want 0", overrun);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        int unsigned t0;
        clear_obs();
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, t0);
            idle($urandom_range(0, 20));
        end
        idle(10);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d, want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_frame_error();
        int unsigned t0;
        int unsigned fe0;
        clear_obs();
        fe0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h61, 1'b0, t0);
        rx = 1'b0;
        idle(20);
        n_checks++;
        if (fe_cnt - fe0 != 1) begin
            n_fail++;
            $display("FAIL ferr_pulses: got %0d, want 1", fe_cnt - fe0);
        end else begin
            n_checks++;
            if (fe_t - t0 != LAT) begin
                n_fail++;
                $display("FAIL ferr_timing: got %0d cycles, want %0d", fe_t - t0, LAT);
            end
        end
        n_checks++;
        if (got_q.size() != 0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_no_data: got %0d bytes v=%b, want 0 0", got_q.size(), rx_valid);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ferr_busy_low_line: got %b, want 1", busy);
        end
        rx = 1'b1;
        idle(5);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_busy_release: got %b, want 0", busy);
        end
    endtask

    task automatic test_glitch();
        int unsigned fe0;
        clear_obs();
        fe0 = fe_cnt;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_detect: got busy=%b, want 1", busy);
        end
        idle(10);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_idle: got busy=%b, want 0", busy);
        end
        idle(CPB * 12);
        n_checks++;
        if (got_q.size() != 0 || fe_cnt != fe0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got bytes=%0d fe=%0d v=%b, want 0 0 0",
                     got_q.size(), fe_cnt - fe0, rx_valid);
        end
    endtask

    task automatic test_overrun();
        logic [7:0]  b0;
        logic [7:0]  b1;
        int unsigned t0;
        b0 = 8'h41;
        b1 = 8'h42;
        clear_obs();
        rx_ready = 1'b0;
        send_frame(b0, 1'b1, t0);
        send_frame(b1, 1'b1, t0);
        idle(5);
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== b0) begin
            n_fail++;
            $display("FAIL ovr_hold: got v=%b data=%h, want 1 %h", rx_valid, rx_data, b0);
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_flag: got %b, want 1", overrun);
        end
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        n_checks++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_consume: got v=%b, want 0", rx_valid);
        end
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== b0) begin
            n_fail++;
            $display("FAIL ovr_accepted: got %0d bytes, want 1 byte %h", got_q.size(), b0);
        end
        idle(3);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got %b, want 1", overrun);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  b;
        int unsigned t0;
        b = 8'($urandom_range(0, 255));
        clear_obs();
        rx_ready = 1'b1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++)
            drive_bit(b[i]);
        rx = b[4];
        idle(CPB / 2);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_data, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL midrst_outputs: got data=%h v=%b fe=%b ovr=%b busy=%b, want 00 0 0 0 0",
                     rx_data, rx_valid, frame_err, overrun, busy);
        end
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(CPB * 12);
        n_checks++;
        if (got_q.size() != 0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_stale: got bytes=%0d v=%b busy=%b, want 0 0 0",
                     got_q.size(), rx_valid, busy);
        end
        send_frame(8'h5A, 1'b1, t0);
        idle(10);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL midrst_next: got %0d bytes first=%h, want 1 byte 5a",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stream();
        test_frame_error();
        test_glitch();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
